spike_window_classifier: RTL and testbench
==========================================

SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

Interface
REQ-001 Parameter: C_S_AXI_ACLK_FREQ_HZ, default 100000000, clock frequency (informational).
REQ-002 Parameter: WINDOW_CYCLES, default 1000000, length of the spike-counting window in clocks (>= 2).
REQ-003 Parameter: SETTLE_CYCLES, default 1000, guard time after a stimulus change during which spikes are ignored (>= 1).
REQ-004 Parameter: CNT_WIDTH, default 16, spike counter width.
REQ-005 S_AXI_ACLK  input  1  sole clock; one clock, all logic on its rising edge.
REQ-006 S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-007 asic_spike_in  input  2  raw output-neuron spike lines from the neuromorphic ASIC, asynchronous to S_AXI_ACLK.
REQ-008 char_select  input  2  current stimulus character from the config register block.
REQ-009 network_output  output  2  classification result, fed to the config register block's network-output read register.
REQ-010 result_valid  output  1  one-clock pulse when network_output is updated.
REQ-011 spike_count0, spike_count1  output  CNT_WIDTH each  final counts of the last completed window.

Function
REQ-012 Each asic_spike_in bit SHALL pass through a two-flop synchronizer, then a rising-edge detector (synced & ~previous synced).
REQ-013 An edge SHALL increment its channel counter on the next clock; raw-input rise to counter change = 4 clocks.
REQ-014 Counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-015 FSM states: SETTLE, COUNT, DECIDE.
REQ-016 SETTLE: counters held at 0, edges discarded; after SETTLE_CYCLES clocks go to COUNT.
REQ-017 COUNT: edges counted; after exactly WINDOW_CYCLES clocks go to DECIDE. An edge detected on the last COUNT clock SHALL be counted.
REQ-018 DECIDE (one clock): network_output, spike_count0/1 registered from the counters; result_valid = 1 for that clock; counters cleared; edges detected in DECIDE discarded; next state COUNT (back-to-back windows).
REQ-019 Result encoding: both counts 0 -> 2'b00; count0 > count1 -> 2'b01; count1 > count0 -> 2'b10; equal and nonzero -> 2'b11.
REQ-020 network_output, spike_count0/1 SHALL hold between DECIDE cycles.
REQ-021 char_select is registered once; any change seen in any state SHALL force SETTLE on the next clock, clear counters and the window timer, set network_output to 2'b00, and suppress result_valid. A change coinciding with DECIDE pre-empts it: no result published.
REQ-022 A further char_select change during SETTLE SHALL restart the SETTLE count.

Reset
REQ-023 Reset SHALL force state SETTLE, timer 0, counters 0, synchronizer/edge flops 0, char_select shadow 0, network_output 2'b00, result_valid 0, spike_count0/1 0.
REQ-024 Reset asserted mid-window SHALL discard the partial window; no result_valid on or after release until a full SETTLE + COUNT completes.
REQ-025 Release is asynchronous at the flops; the first FSM advance is the first rising clock edge with S_AXI_ARESETN high.

Structure
REQ-026 Shared package holds the FSM state encoding and the four result-code constants (NO_SPIKES, NEURON0, NEURON1, TIE).
REQ-027 One sub-module, spike_sync_edge (two-flop synchronizer plus edge detector, one bit), instantiated once per channel.
REQ-028 The window/settle timer width SHALL be ceil(log2(max(WINDOW_CYCLES, SETTLE_CYCLES)+1)).

Verification (WINDOW_CYCLES=100, SETTLE_CYCLES=10, CNT_WIDTH=4)
REQ-029 Reset, then 7 pulses on bit0 and 3 on bit1 inside the window -> network_output=01, spike_count0=7, spike_count1=3, one result_valid pulse at 110 clocks + pipeline offset.
REQ-030 20 pulses on bit1, none on bit0 -> spike_count1=15 (saturated), network_output=10.
REQ-031 4 pulses on each bit -> 2'b11; next window with no pulses -> 2'b00 with result_valid.
REQ-032 char_select 0->2 at window clock 50 -> network_output=00 next clock, no result_valid, next result 110 clocks after the change, pre-change spikes excluded.
REQ-033 Pulse arriving so its edge lands on the last COUNT clock is counted; one landing in DECIDE is counted in neither window.
REQ-034 S_AXI_ARESETN low for 3 clocks mid-window with spikes pending -> all outputs 0 immediately, first result_valid only after a full 10+100-clock sequence.

Source files
------------

// File: rtl/spike_window_classifier_pkg.sv
// Shared FSM state encoding and result codes for the spike-window classifier.
package spike_window_classifier_pkg;

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;

    localparam logic [1:0] NO_SPIKES = 2'b00;
    localparam logic [1:0] NEURON0   = 2'b01;
    localparam logic [1:0] NEURON1   = 2'b10;
    localparam logic [1:0] TIE       = 2'b11;

    function automatic logic [1:0] classify(input logic [31:0] c0, input logic [31:0] c1);
        if (c0 == 32'd0 && c1 == 32'd0) return NO_SPIKES;
        if (c0 > c1)                    return NEURON0;
        if (c1 > c0)                    return NEURON1;
        return TIE;
    endfunction

endpackage

// File: rtl/spike_sync_edge.sv
// One spike line: two-flop synchronizer followed by a registered rising-edge detector.
module spike_sync_edge (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETN,
    input  logic spike_async,
    output logic spike_rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            prev_p2    <= 1'b0;
            spike_rise <= 1'b0;
        end else begin
            sync_p0    <= spike_async;
            sync_p1    <= sync_p0;
            prev_p2    <= sync_p1;
            spike_rise <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/spike_window_classifier.sv
// Counts output-neuron spikes over fixed windows and publishes which neuron won.
module spike_window_classifier
    import spike_window_classifier_pkg::*;
#(
    parameter int C_S_AXI_ACLK_FREQ_HZ = 100000000,
    parameter int WINDOW_CYCLES        = 1000000,
    parameter int SETTLE_CYCLES        = 1000,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic [1:0]           asic_spike_in,
    input  logic [1:0]           char_select,
    output logic [1:0]           network_output,
    output logic                 result_valid,
    output logic [CNT_WIDTH-1:0] spike_count0,
    output logic [CNT_WIDTH-1:0] spike_count1
);

    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]     SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    if (WINDOW_CYCLES < 2)        begin : g_bad_window $error("WINDOW_CYCLES must be >= 2"); end
    if (SETTLE_CYCLES < 1)        begin : g_bad_settle $error("SETTLE_CYCLES must be >= 1"); end
    if (C_S_AXI_ACLK_FREQ_HZ < 1) begin : g_bad_freq   $error("C_S_AXI_ACLK_FREQ_HZ must be positive"); end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        if (en && v != CNT_MAX) return v + 1'b1;
        return v;
    endfunction

    logic [1:0]           rise_p3;
    logic [1:0]           state;
    logic [TMR_W-1:0]     timer;
    logic [1:0]           char_shadow;
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;

    // Input synchronization and edge detection, three clocks deep
    for (genvar ch = 0; ch < 2; ch++) begin : g_sync
        spike_sync_edge u_sync (
            .S_AXI_ACLK    (S_AXI_ACLK),
            .S_AXI_ARESETN (S_AXI_ARESETN),
            .spike_async   (asic_spike_in[ch]),
            .spike_rise    (rise_p3[ch])
        );
    end

    // Window FSM; a stimulus change overrides every state, including DECIDE
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state          <= ST_SETTLE;
            timer          <= '0;
            char_shadow    <= 2'b00;
            cnt0           <= '0;
            cnt1           <= '0;
            network_output <= NO_SPIKES;
            result_valid   <= 1'b0;
            spike_count0   <= '0;
            spike_count1   <= '0;
        end else begin
            result_valid <= 1'b0;
            char_shadow  <= char_select;
            if (char_select != char_shadow) begin
                state          <= ST_SETTLE;
                timer          <= '0;
                cnt0           <= '0;
                cnt1           <= '0;
                network_output <= NO_SPIKES;
            end else begin
                case (state)
                    ST_SETTLE: begin
                        cnt0 <= '0;
                        cnt1 <= '0;
                        if (timer == SETTLE_LAST) begin
                            state <= ST_COUNT;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_COUNT: begin
                        cnt0 <= sat_inc(cnt0, rise_p3[0]);
                        cnt1 <= sat_inc(cnt1, rise_p3[1]);
                        if (timer == WINDOW_LAST) begin
                            state <= ST_DECIDE;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        network_output <= classify(32'(cnt0), 32'(cnt1));
                        spike_count0   <= cnt0;
                        spike_count1   <= cnt1;
                        result_valid   <= 1'b1;
                        cnt0           <= '0;
                        cnt1           <= '0;
                        state          <= ST_COUNT;
                        timer          <= '0;
                    end
                    default: begin
                        state <= ST_SETTLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed bench for spike_window_classifier with a 10-clock settle and 100-clock window.
module tb_spike_window_classifier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] spk = 2'b00;
    logic [1:0] chs = 2'b00;
    logic [1:0] network_output;
    logic       result_valid;
    logic [3:0] spike_count0;
    logic [3:0] spike_count1;

    spike_window_classifier #(
        .C_S_AXI_ACLK_FREQ_HZ (100000000),
        .WINDOW_CYCLES        (100),
        .SETTLE_CYCLES        (10),
        .CNT_WIDTH            (4)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .asic_spike_in  (spk),
        .char_select    (chs),
        .network_output (network_output),
        .result_valid   (result_valid),
        .spike_count0   (spike_count0),
        .spike_count1   (spike_count1)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         rv_total = 0;
    int         rv_cyc = 0;
    int         rv_long = 0;
    logic [1:0] rv_out = 2'b00;
    logic [3:0] rv_c0 = 4'd0;
    logic [3:0] rv_c1 = 4'd0;
    logic       prev_rv = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    // cyc counts rising edges; outputs are captured 1 ns after each edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (result_valid) begin
            if (prev_rv) rv_long++;
            rv_total++;
            rv_cyc = cyc;
            rv_out = network_output;
            rv_c0  = spike_count0;
            rv_c1  = spike_count1;
        end
        prev_rv = result_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int ch);
        spk[ch] = 1'b1;
        tick();
        tick();
        spk[ch] = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_result(input string tag, input int budget);
        int start;
        int n;
        start = rv_total;
        n = 0;
        while (rv_total == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(rv_total != start), 32'd1);
    endtask

    task automatic check_result(input string tag, input int exp_cyc, input logic [1:0] exp_out,
                                input logic [3:0] exp_c0, input logic [3:0] exp_c1);
        check_eq({tag, "_cyc"}, rv_cyc, exp_cyc);
        check_eq({tag, "_out"}, rv_out, exp_out);
        check_eq({tag, "_c0"},  rv_c0,  exp_c0);
        check_eq({tag, "_c1"},  rv_c1,  exp_c1);
    endtask

    initial begin
        int base;
        int r;
        int c;
        int q;

        repeat (3) tick();
        check_eq("rst_out",   network_output, 2'b00);
        check_eq("rst_valid", result_valid,   1'b0);
        check_eq("rst_c0",    spike_count0,   4'd0);
        check_eq("rst_c1",    spike_count1,   4'd0);
        rst_n = 1'b1;
        base = cyc;

        // 7 vs 3 spikes: first result after 10 settle + 100 count + 1 decide clocks
        repeat (15) tick();
        for (int i = 0; i < 7; i++) pulse(0);
        for (int i = 0; i < 3; i++) pulse(1);
        wait_result("t1_seen", 200);
        check_result("t1", base + 111, 2'b01, 4'd7, 4'd3);
        tick();
        check_eq("t1_pulse_width", result_valid, 1'b0);
        r = rv_cyc;

        // 20 spikes on bit1 saturate the 4-bit counter
        for (int i = 0; i < 20; i++) pulse(1);
        wait_result("t2_seen", 200);
        check_result("t2", r + 101, 2'b10, 4'd0, 4'd15);
        r = rv_cyc;

        // Tie, then an empty window
        for (int i = 0; i < 4; i++) begin
            pulse(0);
            pulse(1);
        end
        wait_result("t3a_seen", 200);
        check_result("t3a", r + 101, 2'b11, 4'd4, 4'd4);
        r = rv_cyc;
        wait_result("t3b_seen", 200);
        check_result("t3b", r + 101, 2'b00, 4'd0, 4'd0);

        // Nonzero result, then a stimulus change at window clock 50
        pulse(0);
        pulse(0);
        wait_result("t4a_seen", 200);
        check_result("t4a", rv_cyc, 2'b01, 4'd2, 4'd0);
        r = rv_cyc;
        for (int i = 0; i < 3; i++) pulse(0);
        while (cyc != r + 50) tick();
        chs = 2'b10;
        tick();
        c = cyc;
        check_eq("t4_chg_out",   network_output, 2'b00);
        check_eq("t4_chg_valid", result_valid,   1'b0);
        repeat (15) tick();
        pulse(1);
        wait_result("t4b_seen", 250);
        check_result("t4b", c + 111, 2'b10, 4'd0, 4'd1);
        r = rv_cyc;

        // bit0 edge lands on the last COUNT clock, bit1 edge lands in DECIDE
        while (cyc != r + 96) tick();
        spk[0] = 1'b1;
        tick();
        spk[1] = 1'b1;
        tick();
        tick();
        spk = 2'b00;
        wait_result("t5a_seen", 200);
        check_result("t5a", r + 101, 2'b01, 4'd1, 4'd0);
        r = rv_cyc;
        wait_result("t5b_seen", 200);
        check_result("t5b", r + 101, 2'b00, 4'd0, 4'd0);

        // Known result, then reset mid-window with spikes in flight
        for (int i = 0; i < 5; i++) pulse(0);
        for (int i = 0; i < 2; i++) pulse(1);
        wait_result("t6a_seen", 200);
        check_result("t6a", rv_cyc, 2'b01, 4'd5, 4'd2);
        pulse(0);
        pulse(0);
        spk = 2'b11;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_out",   network_output, 2'b00);
        check_eq("t6_rst_valid", result_valid,   1'b0);
        check_eq("t6_rst_c0",    spike_count0,   4'd0);
        check_eq("t6_rst_c1",    spike_count1,   4'd0);
        chs = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        q = cyc;
        repeat (5) tick();
        spk = 2'b00;
        wait_result("t6b_seen", 250);
        check_result("t6b", q + 111, 2'b00, 4'd0, 4'd0);

        check_eq("valid_one_clock", rv_long,  0);
        check_eq("valid_total",     rv_total, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
